score_display: RTL

Frame-driven score keeper and 4-digit seven-segment driver for the runner game. Sits beside `game_logic`: consumes the 60 Hz frame clock and `gamemode`, counts survival score in BCD, holds a session high score, and scans the board's seven-segment display from the 100 MHz system clock. Its only effect on gameplay is visual; it sits downstream of `game_logic` in the same way `top_beep` does.

---
 rtl/score_display.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// Frame-driven BCD score keeper with session high score and a 4-digit
// multiplexed seven-segment driver (active-low anodes and cathodes).
module score_display #(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SCAN_BITS        = 18,
  parameter int ALT_FRAMES       = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_60hz,
  input  logic [1:0]  gamemode,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        new_record,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int FC_W  = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int ALT_W = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;

  localparam logic [1:0] GM_IDLE  = 2'd0;
  localparam logic [1:0] GM_PLAY  = 2'd1;
  localparam logic [1:0] GM_PAUSE = 2'd2;
  localparam logic [1:0] GM_OVER  = 2'd3;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Returns {g,f,e,d,c,b,a}, active-low; non-decimal codes are blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [2:0]           sync_q;
  logic                 tick_q;
  logic [1:0]           gm_q;
  logic [15:0]          score_q, score_d;
  logic [15:0]          hs_q, hs_d;
  logic                 nr_q, nr_d;
  logic [FC_W-1:0]      fc_q, fc_d;
  logic [ALT_W-1:0]     alt_q, alt_d;
  logic                 show_hi_q, show_hi_d;
  logic [4:0]           blink_q, blink_d;
  logic [SCAN_BITS-1:0] scan_q;
  logic [3:0]           an_q, an_d;
  logic [7:0]           cat_q, cat_d;

  logic        start_ev, end_ev, score_tick;
  logic [1:0]  sel;
  logic [15:0] src;
  logic [3:0]  nib;
  logic        lead_blank, blank_all;

  assign start_ev   = (gamemode == GM_PLAY) && (gm_q == GM_IDLE || gm_q == GM_OVER);
  assign end_ev     = (gamemode == GM_OVER) && (gm_q != GM_OVER);
  assign score_tick = (gm_q == GM_PLAY) && (gamemode == GM_PLAY) && tick_q;

  always_comb begin
    score_d   = score_q;
    hs_d      = hs_q;
    nr_d      = nr_q;
    fc_d      = fc_q;
    alt_d     = alt_q;
    show_hi_d = show_hi_q;
    blink_d   = blink_q;
    if (start_ev) begin
      score_d   = '0;
      fc_d      = '0;
      nr_d      = 1'b0;
      alt_d     = '0;
      show_hi_d = 1'b0;
    end else if (end_ev) begin
      nr_d      = (score_q > hs_q);
      if (score_q > hs_q) hs_d = score_q;
      alt_d     = '0;
      show_hi_d = 1'b0;
    end else if (score_tick) begin
      if (fc_q == FC_W'(FRAMES_PER_POINT - 1)) begin
        fc_d = '0;
        if (score_q != 16'h9999) score_d = bcd_inc(score_q);
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end else if (gm_q == GM_OVER && tick_q) begin
      if (alt_q == ALT_W'(ALT_FRAMES - 1)) begin
        alt_d     = '0;
        show_hi_d = ~show_hi_q;
      end else begin
        alt_d = alt_q + ALT_W'(1);
      end
    end
    // Blink phase only advances while paused; 0..14 visible, 15..29 dark.
    if (gm_q != GM_PAUSE)  blink_d = '0;
    else if (tick_q)       blink_d = (blink_q == 5'd29) ? 5'd0 : blink_q + 5'd1;
  end

  always_comb begin
    sel        = scan_q[SCAN_BITS-1 -: 2];
    src        = (gm_q == GM_OVER && show_hi_q) ? hs_q : score_q;
    nib        = src[{sel, 2'b00} +: 4];
    blank_all  = (gm_q == GM_PAUSE) && (blink_q >= 5'd15);
    lead_blank = 1'b0;
    case (sel)
      2'd3:    lead_blank = (src[15:12] == 4'd0);
      2'd2:    lead_blank = (src[15:8]  == 8'd0);
      2'd1:    lead_blank = (src[15:4]  == 12'd0);
      default: lead_blank = 1'b0;
    endcase
    an_d  = blank_all ? 4'b1111 : ~(4'b0001 << sel);
    cat_d = (blank_all || lead_blank) ? 8'hFF : {1'b1, seg7(nib)};
    if (!blank_all && sel == 2'd3 && gm_q == GM_OVER && show_hi_q) cat_d[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      tick_q    <= 1'b0;
      gm_q      <= GM_IDLE;
      score_q   <= '0;
      hs_q      <= '0;
      nr_q      <= 1'b0;
      fc_q      <= '0;
      alt_q     <= '0;
      show_hi_q <= 1'b0;
      blink_q   <= '0;
      scan_q    <= '0;
      an_q      <= 4'b1111;
      cat_q     <= 8'hFF;
    end else begin
      sync_q    <= {sync_q[1:0], clk_60hz};
      tick_q    <= sync_q[1] & ~sync_q[2];
      gm_q      <= gamemode;
      score_q   <= score_d;
      hs_q      <= hs_d;
      nr_q      <= nr_d;
      fc_q      <= fc_d;
      alt_q     <= alt_d;
      show_hi_q <= show_hi_d;
      blink_q   <= blink_d;
      scan_q    <= scan_q + SCAN_BITS'(1);
      an_q      <= an_d;
      cat_q     <= cat_d;
    end
  end

  assign score      = score_q;
  assign high_score = hs_q;
  assign new_record = nr_q;
  assign seg_an     = an_q;
  assign seg_cat    = cat_q;

endmodule
